// File: rtl/bcd_clock_pkg.sv
// Shared types and helpers for the digital clock BCD stages.
package bcd_clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Binary value of a two-digit BCD pair; 8 bits covers non-BCD inputs up to 15,15.
  function automatic logic [7:0] bcd_to_bin(bcd_t tens, bcd_t units);
    return 8'({4'b0, tens} * 8'd10 + {4'b0, units});
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade with increment/decrement, carry/borrow out and a priority set.
module bcd_digit
  import bcd_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       set,
  input  logic [3:0] set_value,
  output logic [3:0] value,
  output logic       carry,
  output logic       borrow
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (set) begin
      value_d = set_value;
    end else if (inc) begin
      value_d = (value_q >= BCD_MAX) ? 4'd0 : value_q + 4'd1;
    end else if (dec) begin
      value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign carry  = inc & (value_q == BCD_MAX);
  assign borrow = dec & (value_q == 4'd0);

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-decade up/down BCD counter with modulus wrap, parallel load and cascade terminal count.
module bcd_mod_counter
  import bcd_clock_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [7:0] q,
  output logic       tc,
  output logic       load_err
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be in 2..100");
  end

  localparam logic [7:0] ModVal   = 8'(MODULUS);
  localparam logic [7:0] MaxVal   = 8'(MODULUS - 1);
  localparam logic [3:0] TopTens  = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] TopUnits = 4'((MODULUS - 1) % 10);

  logic [3:0] tens_v, units_v;
  logic [7:0] value_bin;
  logic       count, load_ok, wrap_up, wrap_dn, set;
  logic [3:0] set_tens, set_units;
  logic       units_carry, units_borrow;
  logic       tens_carry, tens_borrow;
  logic       load_err_q, load_err_d;

  assign value_bin = bcd_to_bin(tens_v, units_v);
  assign count     = en & ~load;
  assign load_ok   = (load_tens <= BCD_MAX) & (load_units <= BCD_MAX) &
                     (bcd_to_bin(load_tens, load_units) < ModVal);

  // Wrap is judged on the full value so non-decade moduli (e.g. 24) end correctly.
  assign wrap_up = count & up & (value_bin == MaxVal);
  assign wrap_dn = count & ~up & (value_bin == 8'd0);
  assign set     = (load & load_ok) | wrap_up | wrap_dn;

  always_comb begin
    set_tens  = 4'd0;
    set_units = 4'd0;
    if (load) begin
      set_tens  = load_tens;
      set_units = load_units;
    end else if (wrap_dn) begin
      set_tens  = TopTens;
      set_units = TopUnits;
    end
  end

  bcd_digit u_units (
    .clk       (clk),
    .reset     (reset),
    .inc       (count & up),
    .dec       (count & ~up),
    .set       (set),
    .set_value (set_units),
    .value     (units_v),
    .carry     (units_carry),
    .borrow    (units_borrow)
  );

  bcd_digit u_tens (
    .clk       (clk),
    .reset     (reset),
    .inc       (units_carry),
    .dec       (units_borrow),
    .set       (set),
    .set_value (set_tens),
    .value     (tens_v),
    .carry     (tens_carry),
    .borrow    (tens_borrow)
  );

  assign load_err_d = load & ~load_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  logic unused_cascade;
  assign unused_cascade = tens_carry ^ tens_borrow;

  assign tens     = tens_v;
  assign units    = units_v;
  assign q        = {tens_v, units_v};
  assign tc       = en & (up ? (value_bin == MaxVal) : (value_bin == 8'd0));
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter at MODULUS 60 and 24 with a queued scoreboard.
module tb_bcd_mod_counter;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_a = 1'b0, up_a = 1'b1, load_a = 1'b0;
  logic [3:0] lt_a = 4'd0, lu_a = 4'd0;
  logic       en_b = 1'b0, up_b = 1'b1, load_b = 1'b0;
  logic [3:0] lt_b = 4'd0, lu_b = 4'd0;
  logic [3:0] tens_a, units_a, tens_b, units_b;
  logic [7:0] q_a, q_b;
  logic       tc_a, tc_b, err_a, err_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MODULUS(60)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .en         (en_a),
    .up         (up_a),
    .load       (load_a),
    .load_tens  (lt_a),
    .load_units (lu_a),
    .tens       (tens_a),
    .units      (units_a),
    .q          (q_a),
    .tc         (tc_a),
    .load_err   (err_a)
  );

  bcd_mod_counter #(.MODULUS(24)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .en         (en_b),
    .up         (up_b),
    .load       (load_b),
    .load_tens  (lt_b),
    .load_units (lu_b),
    .tens       (tens_b),
    .units      (units_b),
    .q          (q_b),
    .tc         (tc_b),
    .load_err   (err_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one edge on the selected counter (the other idles) and score its outputs after it.
  task automatic step(input int d, input logic rst, input logic e, input logic u,
                      input logic l, input logic [3:0] lt, input logic [3:0] lu,
                      input string tag, input logic [7:0] eq, input logic ee);
    exp_t x;
    logic [7:0] obs_q;
    logic       obs_err;
    reset = rst;
    if (d == 0) begin
      en_a = e; up_a = u; load_a = l; lt_a = lt; lu_a = lu;
      en_b = 1'b0; load_b = 1'b0;
    end else begin
      en_b = e; up_b = u; load_b = l; lt_b = lt; lu_b = lu;
      en_a = 1'b0; load_a = 1'b0;
    end
    sb.push_back('{tag, eq, ee});
    @(posedge clk);
    #1;
    x       = sb.pop_front();
    obs_q   = (d == 0) ? q_a : q_b;
    obs_err = (d == 0) ? err_a : err_b;
    chk({x.tag, ".q"}, obs_q, x.q);
    chk({x.tag, ".err"}, {7'd0, obs_err}, {7'd0, x.err});
    if (d == 0) chk({x.tag, ".digits"}, {tens_a, units_a}, x.q);
    else        chk({x.tag, ".digits"}, {tens_b, units_b}, x.q);
  endtask

  task automatic tc_chk(input int d, input string tag, input logic exp);
    chk({tag, ".tc"}, {7'd0, (d == 0) ? tc_a : tc_b}, {7'd0, exp});
  endtask

  initial begin
    // Reset both counters.
    step(0, 1, 0, 1, 0, 0, 0, "rst_a", 8'h00, 0);
    chk("rst_b.q", q_b, 8'h00);
    chk("rst_b.err", {7'd0, err_b}, 8'h00);
    tc_chk(0, "rst_idle", 0);

    // Count up three, then reset mid-count.
    step(0, 0, 1, 1, 0, 0, 0, "up1", 8'h01, 0);
    step(0, 0, 1, 1, 0, 0, 0, "up2", 8'h02, 0);
    step(0, 0, 1, 1, 0, 0, 0, "up3", 8'h03, 0);
    tc_chk(0, "up3", 0);
    step(0, 1, 1, 1, 0, 0, 0, "rst_mid", 8'h00, 0);

    // Load 58, count to terminal, wrap.
    step(0, 0, 1, 1, 1, 4'd5, 4'd8, "ld58", 8'h58, 0);
    step(0, 0, 1, 1, 0, 0, 0, "up59", 8'h59, 0);
    tc_chk(0, "up59", 1);
    step(0, 0, 1, 1, 0, 0, 0, "wrap00", 8'h00, 0);
    tc_chk(0, "wrap00", 0);

    // Count down from 00.
    up_a = 1'b0;
    #1;
    tc_chk(0, "dn_pre", 1);
    step(0, 0, 1, 0, 0, 0, 0, "dn59", 8'h59, 0);
    step(0, 0, 1, 0, 0, 0, 0, "dn58", 8'h58, 0);
    tc_chk(0, "dn58", 0);
    step(0, 0, 0, 0, 1, 4'd1, 4'd0, "ld10", 8'h10, 0);
    step(0, 0, 1, 0, 0, 0, 0, "dn09", 8'h09, 0);

    // Rejected and accepted loads.
    step(0, 0, 0, 1, 1, 4'd5, 4'd10, "ld5_10", 8'h09, 1);
    step(0, 0, 0, 1, 0, 0, 0, "err_clr", 8'h09, 0);
    step(0, 0, 0, 1, 1, 4'd6, 4'd0, "ld60", 8'h09, 1);
    step(0, 0, 0, 1, 1, 4'd3, 4'd7, "ld37", 8'h37, 0);

    // Load wins over enable; an invalid load with en set leaves state alone.
    step(0, 0, 1, 1, 1, 4'd4, 4'd2, "ld42_en", 8'h42, 0);
    step(0, 0, 1, 1, 1, 4'd10, 4'd0, "ldA0_en", 8'h42, 1);
    step(0, 0, 0, 1, 0, 0, 0, "hold", 8'h42, 0);

    // Reset overrides a pending load.
    step(0, 1, 1, 1, 1, 4'd3, 4'd3, "rst_ld", 8'h00, 0);

    // MODULUS 24: carry at 19, wrap at 23.
    step(1, 0, 1, 1, 1, 4'd1, 4'd9, "b_ld19", 8'h19, 0);
    step(1, 0, 1, 1, 0, 0, 0, "b_up20", 8'h20, 0);
    step(1, 0, 1, 1, 0, 0, 0, "b_up21", 8'h21, 0);
    step(1, 0, 1, 1, 0, 0, 0, "b_up22", 8'h22, 0);
    tc_chk(1, "b_up22", 0);
    step(1, 0, 1, 1, 0, 0, 0, "b_up23", 8'h23, 0);
    tc_chk(1, "b_up23", 1);
    step(1, 0, 1, 1, 0, 0, 0, "b_wrap", 8'h00, 0);
    tc_chk(1, "b_wrap", 0);
    step(1, 0, 1, 0, 0, 0, 0, "b_dn23", 8'h23, 0);
    step(1, 0, 0, 1, 1, 4'd2, 4'd4, "b_ld24", 8'h23, 1);

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
